// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared definitions for the Yutorina bus arbiter: master indices, owner type,
// arbiter state encoding and enable/disable constants.
package yutorina_bus_arbiter_pkg;

   localparam int NUM_MASTERS = 4;

   typedef logic [1:0] owner_t;

   localparam owner_t MASTER_0 = 2'd0;
   localparam owner_t MASTER_1 = 2'd1;
   localparam owner_t MASTER_2 = 2'd2;
   localparam owner_t MASTER_3 = 2'd3;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_t;

   // Active-high one-hot select for a master index.
   function automatic logic [NUM_MASTERS-1:0] master_onehot(input owner_t idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/yutorina_bus_round_robin_picker.sv
// Combinational round-robin picker: first requester in the order start+1,
// start+2, start+3, start (mod 4); the start slot itself can be excluded.
module yutorina_bus_round_robin_picker
   import yutorina_bus_arbiter_pkg::*;
(
   input  logic [3:0] request,
   input  logic [1:0] start,
   input  logic       exclude_start,
   output logic       valid,
   output logic [1:0] winner
);

   owner_t candidate;

   // NOTE: every output of this always_comb gets a default before any branch,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      valid     = DISABLE;
      winner    = start;
      candidate = start;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         candidate = start + 2'(i);
         if (!valid && request[candidate] && !(exclude_start && i == NUM_MASTERS)) begin
            valid  = ENABLE;
            winner = candidate;
         end
      end
   end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with optional hold-limit preemption.
// Grants are registered one-hot active-low; owner steers the master address mux.
module yutorina_bus_arbiter
   import yutorina_bus_arbiter_pkg::*;
#(
   parameter int HOLD_LIMIT = 16
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       master0_request_,
   input  logic       master1_request_,
   input  logic       master2_request_,
   input  logic       master3_request_,
   output logic       master0_grant_,
   output logic       master1_grant_,
   output logic       master2_grant_,
   output logic       master3_grant_,
   output logic [1:0] owner,
   output logic       bus_busy
);

   localparam int HOLD_W = (HOLD_LIMIT < 1) ? 1 : $clog2(HOLD_LIMIT + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_LIMIT);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_LIMIT < 1) ? 0 : HOLD_LIMIT - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   arb_state_t        state;
   arb_state_t        state_d;
   owner_t            owner_d;
   owner_t            last_owner;
   owner_t            last_owner_d;
   logic [HOLD_W-1:0] hold_count;
   logic [HOLD_W-1:0] hold_d;
   logic [HOLD_W-1:0] hold_eff;
   logic              contend_run;
   logic              contend_d;
   logic              take;
   logic [3:0]        grant_n;

   logic [3:0] request;
   logic       owner_requesting;
   logic       other_requesting;
   logic       pick_valid;
   owner_t     pick_winner;

   assign request          = ~{master3_request_, master2_request_, master1_request_, master0_request_};
   assign owner_requesting = request[owner];
   assign other_requesting = |(request & ~master_onehot(owner));

   // A solo run saturates hold_count, so the contended count restarts from
   // zero on the first cycle a competitor shows up.
   assign hold_eff = contend_run ? hold_count : '0;

   yutorina_bus_round_robin_picker u_picker (
      .request       (request),
      .start         (last_owner),
      .exclude_start (state == ARB_OWNED),
      .valid         (pick_valid),
      .winner        (pick_winner)
   );

   always_comb begin
      state_d      = state;
      owner_d      = owner;
      last_owner_d = last_owner;
      hold_d       = hold_count;
      contend_d    = contend_run;
      take         = DISABLE;

      case (state)
         ARB_IDLE: begin
            if (pick_valid) take = ENABLE;
         end
         ARB_OWNED: begin
            if (!owner_requesting) begin
               if (pick_valid) take = ENABLE;
               else            state_d = ARB_IDLE;
            end else if (!other_requesting || HOLD_LIMIT == 0) begin
               if (hold_count != HOLD_MAX) hold_d = hold_count + HOLD_ONE;
               contend_d = DISABLE;
            end else if (hold_eff == HOLD_LAST) begin
               take = ENABLE;
            end else begin
               hold_d    = hold_eff + HOLD_ONE;
               contend_d = ENABLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      // A fresh grant counts its hold time from zero, as if already contended.
      if (take) begin
         state_d      = ARB_OWNED;
         owner_d      = pick_winner;
         last_owner_d = pick_winner;
         hold_d       = '0;
         contend_d    = ENABLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ARB_IDLE;
         owner       <= MASTER_0;
         last_owner  <= MASTER_3;
         hold_count  <= '0;
         contend_run <= DISABLE;
         grant_n     <= 4'hF;
         bus_busy    <= DISABLE;
      end else begin
         state       <= state_d;
         owner       <= owner_d;
         last_owner  <= last_owner_d;
         hold_count  <= hold_d;
         contend_run <= contend_d;
         grant_n     <= (state_d == ARB_OWNED) ? ~master_onehot(owner_d) : 4'hF;
         bus_busy    <= (state_d == ARB_OWNED);
      end
   end

   assign master0_grant_ = grant_n[0];
   assign master1_grant_ = grant_n[1];
   assign master2_grant_ = grant_n[2];
   assign master3_grant_ = grant_n[3];

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Directed bench for yutorina_bus_arbiter (HOLD_LIMIT=4): expected grant/owner/busy
// per edge are queued with the stimulus and compared one edge later.
module tb_yutorina_bus_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req_n = 4'hF;
   logic       g0, g1, g2, g3;
   logic [1:0] owner;
   logic       bus_busy;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [3:0] gn;
      logic [1:0] own;
      logic       busy;
      string      tag;
   } exp_t;

   exp_t sb[$];

   localparam logic [3:0] G_NONE = 4'b1111;
   localparam logic [3:0] G_M0   = 4'b1110;
   localparam logic [3:0] G_M1   = 4'b1101;
   localparam logic [3:0] G_M2   = 4'b1011;
   localparam logic [3:0] G_M3   = 4'b0111;

   yutorina_bus_arbiter #(.HOLD_LIMIT(4)) dut (
      .clock            (clock),
      .reset            (reset),
      .master0_request_ (req_n[0]),
      .master1_request_ (req_n[1]),
      .master2_request_ (req_n[2]),
      .master3_request_ (req_n[3]),
      .master0_grant_   (g0),
      .master1_grant_   (g1),
      .master2_grant_   (g2),
      .master3_grant_   (g3),
      .owner            (owner),
      .bus_busy         (bus_busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive one cycle of stimulus, queue what must appear after the edge, then compare.
   task automatic step(input logic rst, input logic [3:0] rq, input logic [3:0] egn,
                       input logic [1:0] eown, input string tag);
      exp_t e;
      reset = rst;
      req_n = rq;
      e.gn   = egn;
      e.own  = eown;
      e.busy = (egn != G_NONE);
      e.tag  = tag;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check({tag, "_queue"}, 8'd0, 8'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, "_grant"}, {4'b0, g3, g2, g1, g0}, {4'b0, e.gn});
         check({e.tag, "_owner"}, {6'b0, owner}, {6'b0, e.own});
         check({e.tag, "_busy"},  {7'b0, bus_busy}, {7'b0, e.busy});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, including internal registers.
      step(1'b1, 4'hF, G_NONE, 2'd0, "reset");
      check("reset_state", 8'(dut.state), 8'd0);
      check("reset_last_owner", 8'(dut.last_owner), 8'd3);
      check("reset_hold", 8'(dut.hold_count), 8'd0);

      // master2 alone: one-cycle grant latency, then release to idle.
      step(1'b0, 4'b1011, G_M2, 2'd2, "m2_grant");
      step(1'b0, 4'b1111, G_NONE, 2'd2, "m2_release");

      // All four request together after reset; each releases after 3 granted cycles.
      step(1'b1, 4'hF, G_NONE, 2'd0, "reset2");
      step(1'b0, 4'b0000, G_M0, 2'd0, "rr_m0_a");
      step(1'b0, 4'b0000, G_M0, 2'd0, "rr_m0_b");
      step(1'b0, 4'b0000, G_M0, 2'd0, "rr_m0_c");
      step(1'b0, 4'b0001, G_M1, 2'd1, "rr_m1_a");
      step(1'b0, 4'b0001, G_M1, 2'd1, "rr_m1_b");
      step(1'b0, 4'b0001, G_M1, 2'd1, "rr_m1_c");
      step(1'b0, 4'b0011, G_M2, 2'd2, "rr_m2_a");
      step(1'b0, 4'b0011, G_M2, 2'd2, "rr_m2_b");
      step(1'b0, 4'b0011, G_M2, 2'd2, "rr_m2_c");
      step(1'b0, 4'b0111, G_M3, 2'd3, "rr_m3_a");
      step(1'b0, 4'b0111, G_M3, 2'd3, "rr_m3_b");
      step(1'b0, 4'b0111, G_M3, 2'd3, "rr_m3_c");
      step(1'b0, 4'b1111, G_NONE, 2'd3, "rr_idle");

      // After master3 last owned, master0 requests alone.
      step(1'b0, 4'b1110, G_M0, 2'd0, "after_m3_m0");
      step(1'b0, 4'b1111, G_NONE, 2'd0, "after_m3_idle");

      // Preemption: master0 holds alone, then master3 contends for exactly 4 cycles.
      step(1'b0, 4'b1110, G_M0, 2'd0, "pre_m0_grant");
      for (int i = 0; i < 6; i++) step(1'b0, 4'b1110, G_M0, 2'd0, "pre_m0_solo");
      step(1'b0, 4'b0110, G_M0, 2'd0, "pre_hold1");
      step(1'b0, 4'b0110, G_M0, 2'd0, "pre_hold2");
      step(1'b0, 4'b0110, G_M0, 2'd0, "pre_hold3");
      step(1'b0, 4'b0110, G_M3, 2'd3, "pre_move_m3");
      step(1'b0, 4'b0110, G_M3, 2'd3, "pre_m3_hold1");
      step(1'b0, 4'b0110, G_M3, 2'd3, "pre_m3_hold2");
      step(1'b0, 4'b0110, G_M3, 2'd3, "pre_m3_hold3");
      step(1'b0, 4'b0110, G_M0, 2'd0, "pre_back_m0");
      step(1'b0, 4'b1111, G_NONE, 2'd0, "pre_idle");

      // master1 alone for 20 cycles: grant never moves, hold_count saturates.
      step(1'b0, 4'b1101, G_M1, 2'd1, "solo_m1_grant");
      for (int i = 0; i < 20; i++) step(1'b0, 4'b1101, G_M1, 2'd1, "solo_m1");
      check("solo_hold_sat", 8'(dut.hold_count), 8'd4);

      // Reset mid-ownership drops the grant; master1 wins again afterwards.
      step(1'b1, 4'b1101, G_NONE, 2'd0, "rst_mid");
      check("rst_mid_last_owner", 8'(dut.last_owner), 8'd3);
      step(1'b0, 4'b1101, G_M1, 2'd1, "rst_regrant_m1");
      step(1'b0, 4'b1111, G_NONE, 2'd1, "rst_regrant_idle");

      // Simultaneous requests from idle: rotation from master1 picks master3 over master0.
      step(1'b0, 4'b0110, G_M3, 2'd3, "rot_m3");
      step(1'b0, 4'b1111, G_NONE, 2'd3, "rot_idle");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/yutorina_bus_arbiter.md
# yutorina_bus_arbiter

Round-robin bus arbiter for the Yutorina shared bus, one stage upstream of the bus address decoder. It grants the bus to exactly one of four masters at a time. Its `owner` output steers the master-side multiplexer, which places that master's word address on the bus. The address decoder then turns that address into per-slave chip selects.

## Interface
Parameters:
- `HOLD_LIMIT`, default 16: the maximum number of consecutive granted cycles an owner keeps the bus while another master is requesting. 0 means unlimited, with no preemption.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `master0_request_` .. `master3_request_`  in  1 each  active-low bus request.
- `master0_grant_` .. `master3_grant_`  out  1 each  active-low bus grant; at most one low at any time.
- `owner`  out  2  index of the granted master; holds the last owner while idle.
- `bus_busy`  out  1  high while any grant is asserted.

## Operation
- States: `IDLE` (no grant) and `OWNED` (one grant asserted).
- Registers:
  - `state`
  - `owner` (2 b)
  - `last_owner` (2 b)
  - `hold_count` (width `$clog2(HOLD_LIMIT+1)`, minimum 1 b)
- Rotation: the next owner is the first requesting master in the order `last_owner+1`, `last_owner+2`, `last_owner+3`, `last_owner`, all mod 4.
  - Because `last_owner` resets to 3, master0 wins first after reset.
- `IDLE` with any request low: go to `OWNED` with the rotation winner.
  - Update `owner` and `last_owner`, clear `hold_count`.
- `IDLE` with no request: stay in `IDLE`.
- `OWNED`, owner still requesting, and either:
  - no other master requesting → stay, and `hold_count` saturates at `HOLD_LIMIT`; or
  - `HOLD_LIMIT`=0 → stay.
- `OWNED`, owner still requesting, another master requesting, `HOLD_LIMIT`≠0, `hold_count` < `HOLD_LIMIT-1`: stay and increment `hold_count`.
- `OWNED`, owner still requesting, another master requesting, `HOLD_LIMIT`≠0, `hold_count` == `HOLD_LIMIT-1`: preempt.
  - Hand the bus to the rotation winner among the *other* requesters.
  - Clear `hold_count`.
- `OWNED` and the owner releases (request high):
  - if another request is low → direct handover to the rotation winner, with no idle cycle;
  - otherwise → `IDLE`, all grants high.
- Grants and `bus_busy` are registered, decoded from `state`/`owner`. There are no combinational paths from a request to a grant.
- Grants are one-hot active-low. A handover raises the old grant and lowers the new one on the same edge.

## Timing
- Reset, sampled at an edge: after that edge the outputs are:
  - all `masterN_grant_` = 1
  - `owner` = 0
  - `bus_busy` = 0
  - `state` = `IDLE`
  - `last_owner` = 3
  - `hold_count` = 0
- Reset asserted mid-ownership: the grant is dropped at the next edge. No handover is performed.
- Grant latency: a request low before edge k gives a grant low after edge k (1 cycle).
- Release latency: the owner raising its request before edge k gives its grant high after edge k.
- Handover: the new grant is low in the same cycle the old grant goes high.
- Preemption with `HOLD_LIMIT`=L: the owner holds exactly L cycles with a competitor pending, then the grant moves.
- Simultaneous requests from idle: rotation order alone decides the winner.
- A requester that drops its request before being granted is simply skipped.

## Structure
- Shared header `bus.h`:
  - `YUTORINA_BUS_MASTER_0`..`_3` index constants
  - `YutorinaBusOwnerBus` (1:0)
  - `YUTORINA_BUS_ARB_IDLE` / `_OWNED` state encodings
- Existing global headers: enable/disable constants.
- One natural sub-module: `yutorina_bus_round_robin_picker`.
  - Combinational.
  - Inputs: 4-bit active-high request vector, 2-bit start pointer, exclude-owner flag.
  - Outputs: `valid`, 2-bit winner.

## Test plan
- Reset, then master2 requests alone → `master2_grant_`=0 after 1 edge; `owner`=2, `bus_busy`=1, all other grants 1.
- After reset, all four request on the same cycle, each releasing after 3 granted cycles → grant order 0,1,2,3; each grant lasts 3 cycles; no gap between handovers.
- `HOLD_LIMIT`=4: master0 holds indefinitely, master3 requests → master0 granted exactly 4 cycles after master3's request is seen, then `master3_grant_`=0.
- `HOLD_LIMIT`=4: master1 owns with no competitors for 20 cycles → grant never moves; `hold_count` saturates.
- Reset asserted while master1 owns → next edge all grants 1, `owner`=0; after reset release with master1 requesting → master1 granted again.
- Owner releases with no other requests → `IDLE` (all grants 1, `bus_busy`=0); a new request from master0 after master3 last owned → master0 granted.
